// File: rtl/alu_issue.sv
// Issue/writeback stage around a combinational ALU: instruction FIFO, 8x32 register file, settle-timed writeback.
// Optional macro ALU_ISSUE_STATS_EN adds a 16-bit retired-instruction counter output.
module alu_issue #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] data_a,
  output logic [31:0] data_b,
  output logic [31:0] select,
  input  logic [31:0] result_y,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        div_err,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0] retired_cnt,
`endif
  input  logic        clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          full, empty, push, pop;
  logic [31:0]   head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_a_q, data_a_d, data_b_q, data_b_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    dst_q, dst_d;
  logic          wb, guard;
  logic [31:0]   wb_data;
  logic [31:0]   regs_q [8];
  logic          div_err_q;

  // Full/empty from MSB comparison of the extended pointers.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = fifo_mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    op_d     = op_q;
    dst_d    = dst_q;
    pop      = 1'b0;
    wb       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          op_d     = head[3:0];
          dst_d    = head[6:4];
          data_a_d = regs_q[head[9:7]];
          data_b_d = head[13] ? {{16{head[31]}}, head[31:16]} : regs_q[head[12:10]];
          cnt_d    = CW'(ALU_LATENCY);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          wb      = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      op_q     <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
    end
  end

  // Divide (3) and modulo (4) by zero write 0 instead of the ALU output.
  assign guard   = ((op_q == 4'd3) || (op_q == 4'd4)) && (data_b_q == 32'd0);
  assign wb_data = guard ? 32'd0 : result_y;

  // r0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wb && (dst_q != 3'd0)) begin
      regs_q[dst_q] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             div_err_q <= 1'b0;
    else if (wb && guard)   div_err_q <= 1'b1;
    else if (clr_err)       div_err_q <= 1'b0;
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  retired_q <= '0;
    else if (wb) retired_q <= retired_q + 16'd1;
  end
  assign retired_cnt = retired_q;
`endif

  assign data_a  = data_a_q;
  assign data_b  = data_b_q;
  assign select  = {28'b0, op_q};
  assign rd_data = regs_q[rd_addr];
  assign busy    = !empty || (state_q != IDLE);
  assign div_err = div_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: instance a uses ALU_LATENCY=1 with a combinational ALU,
// instance b uses ALU_LATENCY=3 with an ALU whose result settles two edges after its operands.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic [31:0] in_instr_a, in_instr_b;
  logic        in_valid_a, in_valid_b, in_ready_a, in_ready_b;
  logic [31:0] data_a_a, data_b_a, select_a, result_y_a;
  logic [31:0] data_a_b, data_b_b, select_b, result_y_b;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b, div_err_a, div_err_b, clr_err_a, clr_err_b;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] retired_cnt_a, retired_cnt_b;
`endif
  logic [31:0] stage1_b, stage2_b;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.FIFO_DEPTH(4), .ALU_LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n_a), .in_instr(in_instr_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .data_a(data_a_a), .data_b(data_b_a), .select(select_a),
    .result_y(result_y_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a),
    .div_err(div_err_a),
`ifdef ALU_ISSUE_STATS_EN
    .retired_cnt(retired_cnt_a),
`endif
    .clr_err(clr_err_a));

  alu_issue #(.FIFO_DEPTH(4), .ALU_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n_b), .in_instr(in_instr_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .data_a(data_a_b), .data_b(data_b_b), .select(select_b),
    .result_y(result_y_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b),
    .div_err(div_err_b),
`ifdef ALU_ISSUE_STATS_EN
    .retired_cnt(retired_cnt_b),
`endif
    .clr_err(clr_err_b));

  // Reference ALU; divide by zero yields a marker value the guard must replace.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd3:    return (b == 0) ? 32'hDEADBEEF : 32'($signed(a) / $signed(b));
      4'd4:    return (b == 0) ? 32'hDEADBEEF : 32'($signed(a) % $signed(b));
      4'd5:    return b;
      default: return a ^ b;
    endcase
  endfunction

  always_comb result_y_a = alu_model(select_a[3:0], data_a_a, data_b_a);

  always @(posedge clk) begin
    stage1_b <= alu_model(select_b[3:0], data_a_b, data_b_b);
    stage2_b <= stage1_b;
  end
  assign result_y_b = stage2_b;

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                                     input logic [2:0] sb, input logic ims, input logic [15:0] imm);
    return {imm, 2'b00, ims, sb, sa, dst, op};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input bit sel_b, input logic [31:0] w);
    if (sel_b) begin in_instr_b = w; in_valid_b = 1'b1; end
    else       begin in_instr_a = w; in_valid_a = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input bit sel_b, input string tag);
    int n = 0;
    while ((sel_b ? busy_b : busy_a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'b0, sel_b ? busy_b : busy_a}, 32'd0);
  endtask

  task automatic chk_reg(input bit sel_b, input string tag, input logic [2:0] r, input logic [31:0] exp);
    if (sel_b) begin rd_addr_b = r; #1; check_val(tag, rd_data_b, exp); end
    else       begin rd_addr_a = r; #1; check_val(tag, rd_data_a, exp); end
  endtask

  initial begin
    int acc, drop_at;
    logic rdy;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    in_instr_a = '0; in_instr_b = '0; in_valid_a = 1'b0; in_valid_b = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; clr_err_a = 1'b0; clr_err_b = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    check_val("rst_busy", {31'b0, busy_a}, 32'd0);
    check_val("rst_data_a", data_a_a, 32'd0);
    check_val("rst_select", select_a, 32'd0);
    check_val("rst_div_err", {31'b0, div_err_a}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check_val("rst_retired", {16'b0, retired_cnt_a}, 32'd0);
`endif
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // Immediate load: pushed at t, popped at t+1, written at t+2.
    push(1'b0, mk(5, 1, 0, 0, 1, 16'h0007));
    check_val("busy_after_push", {31'b0, busy_a}, 32'd1);
    @(negedge clk);
    check_val("ld_select", select_a, 32'd5);
    check_val("ld_data_b", data_b_a, 32'd7);
    chk_reg(1'b0, "ld_r1_early", 3'd1, 32'd0);
    @(negedge clk);
    chk_reg(1'b0, "ld_r1", 3'd1, 32'd7);
    check_val("ld_busy_done", {31'b0, busy_a}, 32'd0);

    // Add with sign-extended immediate.
    push(1'b0, mk(0, 2, 1, 0, 1, 16'hFFFD));
    @(negedge clk);
    check_val("add_data_b_sext", data_b_a, 32'hFFFFFFFD);
    check_val("add_data_a", data_a_a, 32'd7);
    @(negedge clk);
    chk_reg(1'b0, "add_r2", 3'd2, 32'd4);
`ifdef ALU_ISSUE_STATS_EN
    check_val("retired_two", {16'b0, retired_cnt_a}, 32'd2);
`endif

    // Divide guard and sticky error flag.
    push(1'b0, mk(5, 1, 0, 0, 1, 16'd9));   wait_idle(1'b0, "idle_r1_9");
    push(1'b0, mk(5, 6, 0, 0, 1, 16'h11));  wait_idle(1'b0, "idle_r6");
    push(1'b0, mk(3, 3, 1, 0, 1, 16'd3));   wait_idle(1'b0, "idle_div3");
    chk_reg(1'b0, "div_r3", 3'd3, 32'd3);
    check_val("div_ok_no_err", {31'b0, div_err_a}, 32'd0);
    push(1'b0, mk(3, 3, 1, 0, 1, 16'd0));   wait_idle(1'b0, "idle_div0");
    chk_reg(1'b0, "div0_r3", 3'd3, 32'd0);
    check_val("div0_err_set", {31'b0, div_err_a}, 32'd1);
    clr_err_a = 1'b1;
    @(negedge clk);
    clr_err_a = 1'b0;
    check_val("div_err_cleared", {31'b0, div_err_a}, 32'd0);
    push(1'b0, mk(3, 3, 1, 0, 1, 16'd0));   wait_idle(1'b0, "idle_div0_b");
    check_val("div0_err_again", {31'b0, div_err_a}, 32'd1);
    push(1'b0, mk(4, 6, 1, 0, 1, 16'd0));
    @(negedge clk);
    clr_err_a = 1'b1;                        // coincides with the mod-by-zero writeback edge
    @(negedge clk);
    clr_err_a = 1'b0;
    check_val("div_err_set_wins", {31'b0, div_err_a}, 32'd1);
    chk_reg(1'b0, "mod0_r6", 3'd6, 32'd0);

    // r0 discard and back-to-back dependent increments.
    push(1'b0, mk(5, 0, 0, 0, 1, 16'd5));   wait_idle(1'b0, "idle_r0");
    chk_reg(1'b0, "r0_zero", 3'd0, 32'd0);
    in_instr_a = mk(0, 4, 4, 0, 1, 16'd1);
    in_valid_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    wait_idle(1'b0, "idle_r4");
    chk_reg(1'b0, "chain_r4", 3'd4, 32'd3);

    // Latency 3: operands held for three WAIT cycles, capture on the third edge after the pop.
    push(1'b1, mk(5, 2, 0, 0, 1, 16'h1234));
    @(negedge clk);
    check_val("lat_sel_w1", select_b, 32'd5);
    @(negedge clk);
    check_val("lat_sel_w2", select_b, 32'd5);
    @(negedge clk);
    check_val("lat_sel_w3", select_b, 32'd5);
    check_val("lat_busy_w3", {31'b0, busy_b}, 32'd1);
    chk_reg(1'b1, "lat_r2_early", 3'd2, 32'd0);
    @(negedge clk);
    chk_reg(1'b1, "lat_r2", 3'd2, 32'h1234);
    check_val("lat_busy_done", {31'b0, busy_b}, 32'd0);
    push(1'b1, mk(0, 3, 2, 0, 1, 16'd1));   wait_idle(1'b1, "idle_lat_add");
    chk_reg(1'b1, "lat_r3", 3'd3, 32'h1235);

    // Queue full: six words held valid, each adds a distinct power of two into R5.
    acc = 0; drop_at = -1;
    in_valid_b = 1'b1;
    for (int cyc = 0; cyc < 100 && acc < 6; cyc++) begin
      in_instr_b = mk(0, 5, 5, 0, 1, 16'(1 << acc));
      rdy = in_ready_b;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
      if (!in_ready_b && drop_at < 0) drop_at = acc;
    end
    in_valid_b = 1'b0;
    check_val("full_drop_after", drop_at, 32'd5);
    check_val("full_all_accepted", acc, 32'd6);
    wait_idle(1'b1, "idle_full");
    chk_reg(1'b1, "full_r5_sum", 3'd5, 32'd63);

    // Reset during WAIT with two words still queued.
    in_instr_b = mk(5, 7, 0, 0, 1, 16'h55);
    in_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    check_val("mid_busy_before", {31'b0, busy_b}, 32'd1);
    rst_n_b = 1'b0;
    #1;
    check_val("mid_busy", {31'b0, busy_b}, 32'd0);
    check_val("mid_in_ready", {31'b0, in_ready_b}, 32'd1);
    check_val("mid_select", select_b, 32'd0);
    chk_reg(1'b1, "mid_r5", 3'd5, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    check_val("mid_retired", {16'b0, retired_cnt_b}, 32'd0);
`endif
    @(negedge clk);
    rst_n_b = 1'b1;
    repeat (8) @(negedge clk);
    chk_reg(1'b1, "mid_no_late_wb", 3'd7, 32'd0);
    check_val("mid_idle_after", {31'b0, busy_b}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
